prio_encdec_reg: RTL

//  Parametrised, registered successor to the fixed 3-to-8 decoder: an N-request

---
 rtl/prio_encdec_reg.sv | 125 ++++++++++++
 1 files changed

// File: rtl/prio_encdec_reg.sv
// Registered N-way priority encoder with one-hot decode, valid/ready on both sides, and a saturating grant counter.
// Latency 1 cycle, 1 result/cycle; req_ready = !out_valid | out_ready. Define PRIO_RR_EN for round-robin priority.
module prio_encdec_reg #(
    parameter int N     = 8,
    parameter int W     = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [N-1:0]     req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     idx,
    output logic [N-1:0]     onehot,
    output logic             none,
    output logic [CNT_W-1:0] grant_cnt
);

    if (W != $clog2(N)) begin : g_bad_w
        $error("prio_encdec_reg: W (%0d) must equal $clog2(N) for N=%0d", W, N);
    end

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     idx_q, idx_d;
    logic [N-1:0]     onehot_q, onehot_d;
    logic             none_q, none_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     win_idx;
    logic             win_hit;
    logic             accept;

`ifdef PRIO_RR_EN
    logic [W-1:0]     last_q, last_d;
`endif

    assign out_valid = (state_q == FULL);
    assign req_ready = (state_q == EMPTY) | out_ready;
    assign accept    = req_valid & req_ready;
    assign idx       = idx_q;
    assign onehot    = onehot_q;
    assign none      = none_q;
    assign grant_cnt = cnt_q;

    always_comb begin
        win_idx = '0;
        win_hit = 1'b0;
`ifdef PRIO_RR_EN
        // Walk downward from just below the last grant; W-bit arithmetic gives the wrap.
        for (int k = 0; k < N; k++) begin
            logic [W-1:0] pos;
            pos = last_q - W'(1) - W'(k);
            if (!win_hit && req[pos]) begin
                win_hit = 1'b1;
                win_idx = pos;
            end
        end
`else
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                win_hit = 1'b1;
                win_idx = W'(i);
            end
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        none_d   = none_q;
        cnt_d    = cnt_q;
`ifdef PRIO_RR_EN
        last_d   = last_q;
`endif
        if (accept) begin
            state_d  = FULL;
            idx_d    = win_idx;
            onehot_d = win_hit ? (N'(1) << win_idx) : '0;
            none_d   = !win_hit;
            if (win_hit) begin
                if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
`ifdef PRIO_RR_EN
                last_d = win_idx;
`endif
            end
        end else if (out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EMPTY;
            idx_q    <= '0;
            onehot_q <= '0;
            none_q   <= 1'b0;
            cnt_q    <= '0;
`ifdef PRIO_RR_EN
            last_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            none_q   <= none_d;
            cnt_q    <= cnt_d;
`ifdef PRIO_RR_EN
            last_q   <= last_d;
`endif
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && req_valid && $isunknown(req))
            $error("prio_encdec_reg: X on req while req_valid=1");
    end
`endif

endmodule
